io_output_bank: RTL

//  Parametrised memory-mapped output port bank on the CPU I/O bus, next to the data-memory/IO decode.

---
 rtl/io_output_bank.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/io_output_bank.sv
// Memory-mapped output port bank: byte-lane write/set/clear/toggle ports,
// registered readback, per-port update strobes and a bus-silence watchdog.
module io_output_bank #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned DATA_W    = 32,
  parameter logic [5:0]  BASE_WORD = 6'h20,
  parameter int unsigned WDT_W     = 16
) (
  input  logic                          io_clk,
  input  logic                          clrn,
  input  logic [31:0]                   addr,
  input  logic [DATA_W-1:0]             datain,
  input  logic [DATA_W/8-1:0]           byte_en,
  input  logic                          write_io_enable,
  input  logic                          read_io_enable,
  output logic [DATA_W-1:0]             rdata,
  output logic                          rvalid,
  output logic [NUM_PORTS*DATA_W-1:0]   out_ports,
  output logic [NUM_PORTS-1:0]          port_strobe,
  output logic                          wdt_expired
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam logic [5:0]  REL_TO = 6'(NUM_PORTS);
  localparam logic [5:0]  REL_ST = 6'(NUM_PORTS + 1);

  logic [NUM_PORTS-1:0][DATA_W-1:0] r_ports;
  logic [WDT_W-1:0]                 r_timeout;
  logic [WDT_W-1:0]                 r_cnt;
  logic                             r_expired;
  logic [DATA_W-1:0]                r_rdata;
  logic                             r_rvalid;
  logic [NUM_PORTS-1:0]             r_strobe;

  logic [5:0]                       w_rel;
  logic [1:0]                       w_mode;
  logic [DATA_W-1:0]                w_lane_mask;
  logic [NUM_PORTS-1:0]             w_port_wr;
  logic                             w_to_wr;
  logic                             w_st_w1c;
  logic                             w_expire;
  logic [DATA_W-1:0]                w_to_merged;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_mod;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_ports_nxt;
  logic [WDT_W-1:0]                 w_timeout_nxt;
  logic [WDT_W-1:0]                 w_cnt_nxt;
  logic                             w_expired_nxt;
  logic [DATA_W-1:0]                w_rd_val;
  logic [DATA_W-1:0]                w_rdata_nxt;
  logic                             w_unused_addr;

  assign w_unused_addr = ^{addr[31:10], addr[1:0]};

  // Address decode and byte-lane mask
  always_comb begin
    w_rel       = addr[7:2] - BASE_WORD;
    w_mode      = addr[9:8];
    w_lane_mask = '0;
    for (int k = 0; k < BE_W; k++) begin
      w_lane_mask[8*k +: 8] = {8{byte_en[k]}};
    end
    w_port_wr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_port_wr[i] = write_io_enable && (|byte_en) && (w_rel == 6'(i));
    end
    w_to_wr  = write_io_enable && (w_rel == REL_TO);
    w_st_w1c = write_io_enable && (w_rel == REL_ST) && byte_en[0] && datain[0];
  end

  // Per-port write/set/clear/toggle result, restricted to enabled lanes
  always_comb begin
    w_mod = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      case (w_mode)
        2'b00:   w_mod[i] = datain;
        2'b01:   w_mod[i] = r_ports[i] | datain;
        2'b10:   w_mod[i] = r_ports[i] & ~datain;
        default: w_mod[i] = r_ports[i] ^ datain;
      endcase
      w_mod[i] = (w_mod[i] & w_lane_mask) | (r_ports[i] & ~w_lane_mask);
    end
  end

  // Watchdog: any reload (port or timeout write) pre-empts the 1->0 expiry
  always_comb begin
    w_to_merged   = (datain & w_lane_mask) | (DATA_W'(r_timeout) & ~w_lane_mask);
    w_timeout_nxt = r_timeout;
    w_cnt_nxt     = r_cnt;
    w_expired_nxt = r_expired;
    w_expire      = 1'b0;
    if (w_to_wr) begin
      w_timeout_nxt = WDT_W'(w_to_merged);
      w_cnt_nxt     = WDT_W'(w_to_merged);
    end else if (|w_port_wr) begin
      w_cnt_nxt = r_timeout;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - WDT_W'(1);
      w_expire  = (r_cnt == WDT_W'(1));
    end
    if (w_expire) begin
      w_expired_nxt = 1'b1;
    end else if (w_to_wr || w_st_w1c) begin
      w_expired_nxt = 1'b0;
    end
    w_ports_nxt = r_ports;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_port_wr[i]) begin
        w_ports_nxt[i] = w_mod[i];
      end else if (w_expire) begin
        w_ports_nxt[i] = '0;
      end
    end
  end

  // Readback mux, sampled from pre-write state
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_rel == 6'(i)) begin
        w_rd_val = r_ports[i];
      end
    end
    if (w_rel == REL_TO) begin
      w_rd_val = DATA_W'(r_timeout);
    end else if (w_rel == REL_ST) begin
      w_rd_val = DATA_W'({r_cnt, r_expired});
    end
    w_rdata_nxt = read_io_enable ? w_rd_val : r_rdata;
  end

  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      r_ports   <= '0;
      r_timeout <= '0;
      r_cnt     <= '0;
      r_expired <= 1'b0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_strobe  <= '0;
    end else begin
      r_ports   <= w_ports_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
      r_expired <= w_expired_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rvalid  <= read_io_enable;
      r_strobe  <= w_port_wr | {NUM_PORTS{w_expire}};
    end
  end

  assign out_ports   = r_ports;
  assign port_strobe = r_strobe;
  assign rdata       = r_rdata;
  assign rvalid      = r_rvalid;
  assign wdt_expired = r_expired;

endmodule
